// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: recovers pixel coordinates from hsync/vsync edges,
// checks line/frame timing, tracks lock and re-emits visible pixels as strobes.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int H_ACT_START = 144,
  parameter int V_ACT_START = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixel_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic [7:0]  err_cnt
);

  // state    | meaning
  // UNLOCKED | no timing confidence; waiting for a frame boundary
  // ACQUIRE  | one clean frame must pass before locking
  // LOCKED   | timing verified; visible pixels are emitted
  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ST    = 10'(H_ACT_START);
  localparam logic [9:0]  V_ST    = 10'(V_ACT_START);
  localparam logic [10:0] H_END   = 11'(H_ACT_START + H_ACT);
  localparam logic [10:0] V_END   = 11'(V_ACT_START + V_ACT);

  state_t      state, state_nxt;
  logic        hs_prev, hs_prev_nxt, vs_prev, vs_prev_nxt;
  logic [9:0]  h_cnt, h_cnt_nxt, v_cnt, v_cnt_nxt;
  logic        v_arm, v_arm_nxt;
  logic        line_seen, line_seen_nxt, frame_seen, frame_seen_nxt;
  logic [7:0]  err_cnt_nxt;
  logic        pix_valid_nxt, frame_start_nxt, locked_nxt;
  logic [9:0]  pix_x_nxt, pix_y_nxt;
  logic [11:0] pix_rgb_nxt;
  logic        hs_fall, vs_fall, v_reset;
  logic        line_err, sat_err, frame_err, err;
  logic        h_vis, v_vis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= UNLOCKED;
      hs_prev     <= 1'b1;
      vs_prev     <= 1'b1;
      h_cnt       <= '0;
      v_cnt       <= '0;
      v_arm       <= 1'b0;
      line_seen   <= 1'b0;
      frame_seen  <= 1'b0;
      err_cnt     <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
    end else begin
      state       <= state_nxt;
      hs_prev     <= hs_prev_nxt;
      vs_prev     <= vs_prev_nxt;
      h_cnt       <= h_cnt_nxt;
      v_cnt       <= v_cnt_nxt;
      v_arm       <= v_arm_nxt;
      line_seen   <= line_seen_nxt;
      frame_seen  <= frame_seen_nxt;
      err_cnt     <= err_cnt_nxt;
      pix_valid   <= pix_valid_nxt;
      frame_start <= frame_start_nxt;
      locked      <= locked_nxt;
      pix_x       <= pix_x_nxt;
      pix_y       <= pix_y_nxt;
      pix_rgb     <= pix_rgb_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    hs_prev_nxt     = hs_prev;
    vs_prev_nxt     = vs_prev;
    h_cnt_nxt       = h_cnt;
    v_cnt_nxt       = v_cnt;
    v_arm_nxt       = v_arm;
    line_seen_nxt   = line_seen;
    frame_seen_nxt  = frame_seen;
    err_cnt_nxt     = err_cnt;
    pix_valid_nxt   = 1'b0;
    frame_start_nxt = 1'b0;
    pix_x_nxt       = pix_x;
    pix_y_nxt       = pix_y;
    pix_rgb_nxt     = pix_rgb;
    hs_fall         = 1'b0;
    vs_fall         = 1'b0;
    v_reset         = 1'b0;
    line_err        = 1'b0;
    sat_err         = 1'b0;
    frame_err       = 1'b0;
    err             = 1'b0;
    h_vis           = 1'b0;
    v_vis           = 1'b0;

    if (pixel_tick) begin
      hs_fall     = hs_prev & ~hsync;
      vs_fall     = vs_prev & ~vsync;
      v_reset     = hs_fall & v_arm;
      hs_prev_nxt = hsync;
      vs_prev_nxt = vsync;

      if (hs_fall)              h_cnt_nxt = '0;
      else if (h_cnt != CNT_MAX) h_cnt_nxt = h_cnt + 10'd1;

      if (v_reset)                          v_cnt_nxt = '0;
      else if (hs_fall && v_cnt != CNT_MAX) v_cnt_nxt = v_cnt + 10'd1;

      v_arm_nxt = vs_fall | (v_arm & ~hs_fall);

      // Saturation is flagged only on the step into 1023, so a stuck hsync counts once.
      line_err  = hs_fall & line_seen & (h_cnt != H_LAST);
      sat_err   = ~hs_fall & (h_cnt == CNT_MAX - 10'd1);
      frame_err = v_reset & frame_seen & (v_cnt != V_LAST);
      err       = line_err | sat_err | frame_err;

      if (hs_fall) line_seen_nxt  = 1'b1;
      if (v_reset) frame_seen_nxt = 1'b1;

      if (err) begin
        state_nxt      = UNLOCKED;
        line_seen_nxt  = 1'b0;
        frame_seen_nxt = 1'b0;
        if (err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
      end else begin
        case (state)
          UNLOCKED: if (v_reset) state_nxt = ACQUIRE;
          ACQUIRE:  if (v_reset) state_nxt = LOCKED;
          default:  state_nxt = state;
        endcase
      end

      h_vis = (h_cnt_nxt >= H_ST) && ({1'b0, h_cnt_nxt} < H_END);
      v_vis = (v_cnt_nxt >= V_ST) && ({1'b0, v_cnt_nxt} < V_END);
      if (state == LOCKED && h_vis && v_vis) begin
        pix_valid_nxt   = 1'b1;
        pix_x_nxt       = h_cnt_nxt - H_ST;
        pix_y_nxt       = v_cnt_nxt - V_ST;
        pix_rgb_nxt     = rgb;
        frame_start_nxt = (h_cnt_nxt == H_ST) && (v_cnt_nxt == V_ST);
      end
    end

    locked_nxt = (state_nxt == LOCKED);
  end

endmodule
